// File: rtl/mem_dm_access.sv
// MEM-stage data-memory access unit: one req/ack bus transaction per load/store, stalls until done.
// Optional misaligned-access trap selected by defining MISALIGN_TRAP_EN.
module mem_dm_access #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MEM_MemRead,
    input  logic              MEM_MemWrite,
    input  logic [2:0]        MEM_funct3,
    input  logic [ADDR_W-1:0] MEM_addr,
    input  logic [31:0]       MEM_store_data,
    input  logic              im_stall,
    input  logic              CSR_stall,
    input  logic              CSR_reset,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_wstrb,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic [31:0]       MEM_data_memory,
    output logic              dm_stall,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE,
        DRAIN
    } state_t;

    state_t state, state_nx;

    logic        access;
    logic        is_write;
    logic        start;
    logic        mis_c;
    logic [3:0]  strb_c;
    logic [31:0] wdata_c;

    assign access   = MEM_MemRead | MEM_MemWrite;
    assign is_write = ~MEM_MemRead & MEM_MemWrite;
    assign start    = (state == IDLE) & access & ~CSR_reset;

    always_comb begin
        strb_c  = 4'b1111;
        wdata_c = MEM_store_data;
        case (MEM_funct3[1:0])
            2'b00: begin
                strb_c  = 4'b0001 << MEM_addr[1:0];
                wdata_c = {4{MEM_store_data[7:0]}};
            end
            2'b01: begin
                strb_c  = 4'b0011 << {MEM_addr[1], 1'b0};
                wdata_c = {2{MEM_store_data[15:0]}};
            end
            default: begin
                strb_c  = 4'b1111;
                wdata_c = MEM_store_data;
            end
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        mis_c = 1'b0;
        case (MEM_funct3[1:0])
            2'b00:   mis_c = 1'b0;
            2'b01:   mis_c = MEM_addr[0];
            default: mis_c = |MEM_addr[1:0];
        endcase
    end
`else
    assign mis_c    = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (start) state_nx = mis_c ? DONE : REQ;
            REQ: begin
                if (dm_ack)         state_nx = CSR_reset ? IDLE : DONE;
                else if (CSR_reset) state_nx = DRAIN;
            end
            // A request in flight must still see its ack before the bus goes quiet
            DRAIN: if (dm_ack) state_nx = IDLE;
            DONE:  if (CSR_reset | ~(im_stall | CSR_stall)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign dm_req   = (state == REQ) | (state == DRAIN);
    assign dm_stall = reset & (start | (state == REQ) | (state == DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            dm_we           <= 1'b0;
            dm_addr         <= '0;
            dm_wstrb        <= '0;
            dm_wdata        <= '0;
            MEM_data_memory <= '0;
        end else begin
            state <= state_nx;
            if (start & ~mis_c) begin
                dm_addr  <= {MEM_addr[ADDR_W-1:2], 2'b00};
                dm_we    <= is_write;
                dm_wstrb <= is_write ? strb_c : 4'b0000;
                dm_wdata <= wdata_c;
            end
            if ((state == REQ) & dm_ack & ~CSR_reset & ~dm_we)
                MEM_data_memory <= dm_rdata;
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) misalign <= 1'b0;
        else        misalign <= start & mis_c;
    end
`endif

endmodule

// File: tb/tb_mem_dm_access.sv
// Self-checking bench for mem_dm_access: transaction-level reference model driving a per-cycle checker.
module tb_mem_dm_access;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MEM_MemRead = 1'b0, MEM_MemWrite = 1'b0;
    logic [2:0]  MEM_funct3 = '0;
    logic [31:0] MEM_addr = '0, MEM_store_data = '0;
    logic        im_stall = 1'b0, CSR_stall = 1'b0, CSR_reset = 1'b0;
    logic        dm_req, dm_we, dm_stall, misalign;
    logic [31:0] dm_addr, dm_wdata, MEM_data_memory;
    logic [3:0]  dm_wstrb;
    logic        dm_ack = 1'b0;
    logic [31:0] dm_rdata = '0;

    mem_dm_access #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite), .MEM_funct3(MEM_funct3),
        .MEM_addr(MEM_addr), .MEM_store_data(MEM_store_data),
        .im_stall(im_stall), .CSR_stall(CSR_stall), .CSR_reset(CSR_reset),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .MEM_data_memory(MEM_data_memory), .dm_stall(dm_stall), .misalign(misalign)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int stall_cnt = 0, req_rises = 0, mis_cnt = 0;
    logic prev_req = 1'b0;
    logic chk_en = 1'b0;

    // expected outputs for the current cycle
    logic        e_req = 0, e_stall = 0, e_we = 0, e_mis = 0;
    logic [31:0] e_addr = '0, e_wdata = '0, e_mdm = '0;
    logic [3:0]  e_wstrb = '0;

    // model state: last bus transaction launched and last load word captured
    logic        m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_mdm = '0;
    logic [3:0]  m_wstrb = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("dm_req", 32'(dm_req), 32'(e_req));
            check("dm_stall", 32'(dm_stall), 32'(e_stall));
            check("misalign", 32'(misalign), 32'(e_mis));
            check("dm_we", 32'(dm_we), 32'(e_we));
            check("dm_addr", dm_addr, e_addr);
            check("dm_wstrb", 32'(dm_wstrb), 32'(e_wstrb));
            if (e_we) check("dm_wdata", dm_wdata, e_wdata);
            check("MEM_data_memory", MEM_data_memory, e_mdm);
            stall_cnt += int'(dm_stall);
            mis_cnt   += int'(misalign);
            if (dm_req && !prev_req) req_rises++;
            prev_req = dm_req;
        end
    end

    // Byte lanes from size and alignment: bytes [lo, lo+size) enabled, data repeated every size bytes
    task automatic exp_bus(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d,
                           output logic we, output logic [31:0] addr, output logic [3:0] strb,
                           output logic [31:0] wd, output logic mis);
        int unsigned sz, lo;
        sz   = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        lo   = a[1:0] - (a[1:0] % sz);
        we   = wr && !rd;
        addr = a - (a % 4);
        mis  = (a[1:0] % sz) != 0;
        for (int unsigned i = 0; i < 4; i++) begin
            strb[i]       = we && (i >= lo) && (i < lo + sz);
            wd[8*i +: 8]  = d[8*(i % sz) +: 8];
        end
    endtask

    task automatic set_idle_exp();
        e_req = 0; e_stall = 0; e_mis = 0;
        e_we = m_we; e_addr = m_addr; e_wstrb = m_wstrb; e_wdata = m_wdata; e_mdm = m_mdm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        MEM_MemRead = 0; MEM_MemWrite = 0; CSR_reset = 0;
        set_idle_exp();
        tick();
    endtask

    // D: REQ cycle index at which ack arrives; hold: frozen cycles in DONE; flush_k: REQ index of CSR_reset (-1 none)
    task automatic run_txn(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                           input int D, input int hold, input int flush_k, input logic use_csr);
        logic nwe, mis, trap;
        logic [31:0] naddr, nwd;
        logic [3:0] nst;
        exp_bus(rd, wr, f3, a, d, nwe, naddr, nst, nwd, mis);
        trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap = mis;
`endif
        MEM_MemRead = rd; MEM_MemWrite = wr; MEM_funct3 = f3; MEM_addr = a; MEM_store_data = d;
        set_idle_exp();
        e_stall = 1;
        tick();
        if (!trap) begin
            m_we = nwe; m_addr = naddr; m_wstrb = nst; m_wdata = nwd;
            for (int k = 0; k <= D; k++) begin
                set_idle_exp();
                e_req = 1; e_stall = 1;
                dm_ack = (k == D);
                dm_rdata = (k == D) ? rdata : $urandom;
                CSR_reset = (k == flush_k);
                tick();
                if (k == flush_k) begin
                    CSR_reset = 0; dm_ack = 0; MEM_MemRead = 0; MEM_MemWrite = 0;
                    for (int j = k + 1; j <= D; j++) begin
                        set_idle_exp();
                        e_req = 1; e_stall = 1;
                        dm_ack = (j == D);
                        dm_rdata = $urandom;
                        tick();
                    end
                    dm_ack = 0;
                    return;
                end
            end
            dm_ack = 0;
            if (rd) m_mdm = rdata;
        end
        for (int h = 0; h <= hold; h++) begin
            set_idle_exp();
            e_mis = trap && (h == 0);
            if (use_csr) CSR_stall = (h < hold);
            else         im_stall  = (h < hold);
            tick();
        end
        im_stall = 0; CSR_stall = 0;
    endtask

    function automatic logic [2:0] pick_f3();
        logic [2:0] tbl [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        return tbl[$urandom_range(0, 4)];
    endfunction

    initial begin
        // reset state
        set_idle_exp();
        chk_en = 1;
        tick();
        tick();
        reset = 1;
        tick();

        // LW 0x100, same-cycle ack
        stall_cnt = 0;
        run_txn(1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, -1, 0);
        check("lw_stall_cycles", 32'(stall_cnt), 32'd2);
        idle_cycle();
        check("lw_data", MEM_data_memory, 32'hDEADBEEF);
        check("lw_addr", dm_addr, 32'h100);
        check("lw_wstrb", 32'(dm_wstrb), 32'h0);

        // SB / SH
        run_txn(0, 1, 3'd0, 32'h203, 32'h123456AB, 32'h0, 0, 0, -1, 0);
        idle_cycle();
        check("sb_we", 32'(dm_we), 32'd1);
        check("sb_addr", dm_addr, 32'h200);
        check("sb_wstrb", 32'(dm_wstrb), 32'h8);
        check("sb_wdata", dm_wdata, 32'hABABABAB);
        check("sb_keeps_load", MEM_data_memory, 32'hDEADBEEF);
        run_txn(0, 1, 3'd1, 32'h202, 32'h0000CAFE, 32'h0, 1, 0, -1, 0);
        idle_cycle();
        check("sh_wstrb", 32'(dm_wstrb), 32'hC);
        check("sh_wdata", dm_wdata, 32'hCAFECAFE);

        // LH with 3-cycle ack delay
        stall_cnt = 0; req_rises = 0;
        run_txn(1, 0, 3'd1, 32'h46, 32'h0, 32'h0BADF00D, 3, 0, -1, 0);
        check("lh_stall_cycles", 32'(stall_cnt), 32'd5);
        check("lh_req_pulses", 32'(req_rises), 32'd1);
        idle_cycle();

        // Load completing under a 4-cycle im_stall freeze
        req_rises = 0;
        run_txn(1, 0, 3'd2, 32'h80, 32'h0, 32'h13572468, 1, 4, -1, 0);
        check("frozen_req_pulses", 32'(req_rises), 32'd1);
        idle_cycle();
        check("frozen_data", MEM_data_memory, 32'h13572468);

        // Flush before ack -> DRAIN, then flush with same-cycle ack
        run_txn(1, 0, 3'd2, 32'h300, 32'h0, 32'hFFFF0000, 3, 0, 1, 0);
        idle_cycle();
        check("drain_no_capture", MEM_data_memory, 32'h13572468);
        run_txn(1, 0, 3'd2, 32'h304, 32'h0, 32'hFFFF0001, 1, 0, 1, 0);
        idle_cycle();
        check("flush_ack_no_capture", MEM_data_memory, 32'h13572468);

        // Access arriving together with a flush is dropped
        MEM_MemRead = 1; MEM_addr = 32'h500; CSR_reset = 1;
        set_idle_exp();
        tick();
        idle_cycle();

        // Misaligned word load
        req_rises = 0; mis_cnt = 0;
        run_txn(1, 0, 3'd2, 32'h102, 32'h0, 32'h55AA55AA, 0, 0, -1, 0);
        idle_cycle();
`ifdef MISALIGN_TRAP_EN
        check("trap_no_req", 32'(req_rises), 32'd0);
        check("trap_mis_pulses", 32'(mis_cnt), 32'd1);
        check("trap_no_capture", MEM_data_memory, 32'h13572468);
`else
        check("trunc_addr", dm_addr, 32'h100);
        check("trunc_data", MEM_data_memory, 32'h55AA55AA);
        check("no_mis", 32'(mis_cnt), 32'd0);
`endif

        // Randomized transactions
        for (int n = 0; n < 200; n++) begin
            int op, D, fk;
            op = $urandom_range(0, 2);
            D  = $urandom_range(0, 4);
            fk = ($urandom_range(0, 7) == 0) ? $urandom_range(0, D) : -1;
            run_txn(op != 1, op != 0, pick_f3(), $urandom, $urandom, $urandom,
                    D, $urandom_range(0, 3), fk, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        // Asynchronous reset in the middle of a request
        MEM_MemRead = 1; MEM_funct3 = 3'd2; MEM_addr = 32'h700;
        set_idle_exp();
        e_stall = 1;
        tick();
        chk_en = 0;
        #2 reset = 0;
        #1;
        check("arst_req", 32'(dm_req), 32'd0);
        check("arst_stall", 32'(dm_stall), 32'd0);
        check("arst_addr", dm_addr, 32'h0);
        check("arst_we_strb", {dm_we, dm_wstrb}, 32'h0);
        check("arst_wdata", dm_wdata, 32'h0);
        check("arst_data", MEM_data_memory, 32'h0);
        check("arst_mis", 32'(misalign), 32'd0);
        MEM_MemRead = 0;
        m_we = 0; m_addr = '0; m_wstrb = '0; m_wdata = '0; m_mdm = '0;
        reset = 1;
        set_idle_exp();
        tick();
        chk_en = 1;
        run_txn(0, 1, 3'd2, 32'h704, 32'h89ABCDEF, 32'h0, 2, 0, -1, 0);
        idle_cycle();
        chk_en = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
